// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch sequencer's control, instruction-memory and datapath
// strobe signals. The sequencer uses the master side; the surrounding
// datapath / memory / controller uses the slave side.
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 17
);
    logic               start;
    logic               stall;
    logic [INSTR_W-1:0] instr_in;
    logic               eq_flag;
    logic [ADDR_W-1:0]  pc;
    logic               ir_enable;
    logic [INSTR_W-1:0] ir;
    logic               alu_en;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               halted;
    logic               busy;

    modport master (
        input  start, stall, instr_in, eq_flag,
        output pc, ir_enable, ir, alu_en, reg_write, mem_read, mem_write,
               halted, busy
    );

    modport slave (
        output start, stall, instr_in, eq_flag,
        input  pc, ir_enable, ir, alu_en, reg_write, mem_read, mem_write,
               halted, busy
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch / decode / execute / writeback sequencer. Owns the
// program counter and the instruction register, decodes the 4-bit opcode
// in ir[15:12] and issues one-cycle datapath strobes. A JUMP whose target
// equals its own address parks the machine in HALT until the next start.
module fetch_sequencer #(
    parameter int ADDR_W     = 6,
    parameter int INSTR_W    = 17,
    parameter int START_ADDR = 1
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        OP_ALU   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_BEQ   = 3'd3,
        OP_JUMP  = 3'd4,
        OP_NOP   = 3'd5
    } op_class_e;

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] ir_q;

    op_class_e          op;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  beq_tgt;
    logic [ADDR_W-1:0]  jump_tgt;
    logic               active;

    function automatic op_class_e decode_op(input logic [3:0] opc);
        case (opc)
            4'b0000, 4'b0100, 4'b0101, 4'b0110: decode_op = OP_ALU;
            4'b1001:                            decode_op = OP_LOAD;
            4'b1010:                            decode_op = OP_STORE;
            4'b0111:                            decode_op = OP_BEQ;
            4'b1011:                            decode_op = OP_JUMP;
            default:                            decode_op = OP_NOP;
        endcase
    endfunction

    // Opcode class and next-PC candidates, all derived from the latched IR
    always_comb begin
        op       = decode_op(ir_q[15:12]);
        pc_inc   = pc_q + PC_ONE;
        beq_tgt  = pc_q + ADDR_W'(ir_q[3:0]);
        jump_tgt = ir_q[ADDR_W-1:0];
    end

    // Sequencer: state, program counter and instruction register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            ir_q    <= '0;
        end else if (!bus.stall) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        pc_q    <= START_PC;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir_q    <= bus.instr_in;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (op)
                        OP_ALU, OP_LOAD: begin
                            state_q <= S_WRITEBACK;
                        end
                        OP_BEQ: begin
                            pc_q    <= bus.eq_flag ? beq_tgt : pc_inc;
                            state_q <= S_FETCH;
                        end
                        OP_JUMP: begin
                            if (jump_tgt == pc_q) begin
                                state_q <= S_HALT;
                            end else begin
                                pc_q    <= jump_tgt;
                                state_q <= S_FETCH;
                            end
                        end
                        default: begin
                            // STORE and NOP simply advance
                            pc_q    <= pc_inc;
                            state_q <= S_FETCH;
                        end
                    endcase
                end
                S_WRITEBACK: begin
                    pc_q    <= pc_inc;
                    state_q <= S_FETCH;
                end
                S_HALT: begin
                    if (bus.start) begin
                        pc_q    <= START_PC;
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode registered state and IR; stall masks them so each fires
    // only in the one non-stalled cycle that actually advances its state
    always_comb begin
        active        = !bus.stall;
        bus.ir_enable = active && (state_q == S_FETCH);
        bus.alu_en    = active && (state_q == S_EXECUTE) &&
                        (op == OP_ALU || op == OP_LOAD ||
                         op == OP_STORE || op == OP_BEQ);
        bus.mem_read  = active && (state_q == S_EXECUTE) && (op == OP_LOAD);
        bus.mem_write = active && (state_q == S_EXECUTE) && (op == OP_STORE);
        bus.reg_write = active && (state_q == S_WRITEBACK);
        bus.halted    = (state_q == S_HALT);
        bus.busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
        bus.pc        = pc_q;
        bus.ir        = ir_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a cycle table for the main opcode
// walk, then hand-written sequences for halt, stall, reset, wrap and a
// Fibonacci loop run against a small behavioural datapath.
module tb_fetch_sequencer;

    localparam logic [6:0] X_IDLE = 7'b0000000; // {ir_en,alu,rw,mr,mw,halted,busy}
    localparam logic [6:0] X_FET  = 7'b1000001;
    localparam logic [6:0] X_DEC  = 7'b0000001;
    localparam logic [6:0] X_ALU  = 7'b0100001;
    localparam logic [6:0] X_WB   = 7'b0010001;
    localparam logic [6:0] X_LD   = 7'b0101001;
    localparam logic [6:0] X_ST   = 7'b0100101;
    localparam logic [6:0] X_NOP  = 7'b0000001;
    localparam logic [6:0] X_HALT = 7'b0000010;

    typedef struct {
        logic        start;
        logic        stall;
        logic        eq;
        logic [5:0]  pc;
        logic [16:0] ir;
        logic [6:0]  strb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [16:0] imem [64];
    logic [15:0] regs [16];
    logic        use_model;
    logic        eq_drv;
    int          n_cmp = 0;
    int          n_err = 0;
    vec_t        vecs[$];

    fetch_sequencer_if #(.ADDR_W(6), .INSTR_W(17)) bus ();

    fetch_sequencer #(.ADDR_W(6), .INSTR_W(17), .START_ADDR(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.instr_in = imem[bus.pc];
    assign bus.eq_flag  = use_model ? (regs[bus.ir[11:8]] == regs[bus.ir[7:4]])
                                    : eq_drv;

    // Behavioural datapath: rd = rs + rt on reg_write (ADD only)
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            regs[2]  <= 16'd1;
            regs[11] <= 16'd7;
            regs[12] <= 16'd1;
        end else if (use_model && bus.reg_write) begin
            regs[bus.ir[11:8]] <= regs[bus.ir[7:4]] + regs[bus.ir[3:0]];
        end
    end

    function automatic logic [6:0] strb();
        return {bus.ir_enable, bus.alu_en, bus.reg_write, bus.mem_read,
                bus.mem_write, bus.halted, bus.busy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sl, input logic eq);
        bus.start = st;
        bus.stall = sl;
        eq_drv    = eq;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    // From a FETCH cycle, run until the next FETCH or HALT; n = cycles taken
    task automatic run_instr(input logic eq, output int n);
        drive(1'b0, 1'b0, eq);
        tick();
        n = 1;
        while (!(bus.ir_enable || bus.halted) && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic add(input logic st, input logic sl, input logic eq,
                       input logic [5:0] p, input logic [16:0] i, input logic [6:0] s);
        vec_t v;
        v.start = st; v.stall = sl; v.eq = eq; v.pc = p; v.ir = i; v.strb = s;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        use_model = 1'b0;
        for (int i = 0; i < 64; i++) imem[i] = 17'h0F000;

        // ---------------- table: opcode walk ----------------
        imem[1] = 17'h00678;  // ADD
        imem[2] = 17'h0F000;  // opcode 1111 -> NOP
        imem[3] = 17'h0A000;  // STORE
        imem[4] = 17'h09000;  // LOAD
        imem[5] = 17'h07AB2;  // BEQ imm 2
        imem[6] = 17'h0B001;  // JUMP 1
        imem[7] = 17'h0B005;  // JUMP 5

        add(1,0,0, 6'd1, 17'h00000, X_IDLE);
        add(0,0,0, 6'd1, 17'h00000, X_FET);
        add(0,0,0, 6'd1, 17'h00678, X_DEC);
        add(0,0,0, 6'd1, 17'h00678, X_ALU);
        add(0,0,0, 6'd1, 17'h00678, X_WB);
        add(0,0,0, 6'd2, 17'h00678, X_FET);
        add(1,0,0, 6'd2, 17'h0F000, X_DEC);   // start ignored while busy
        add(0,0,0, 6'd2, 17'h0F000, X_NOP);
        add(0,0,0, 6'd3, 17'h0F000, X_FET);
        add(0,0,0, 6'd3, 17'h0A000, X_DEC);
        add(0,0,0, 6'd3, 17'h0A000, X_ST);
        add(0,0,0, 6'd4, 17'h0A000, X_FET);
        add(0,0,0, 6'd4, 17'h09000, X_DEC);
        add(0,0,0, 6'd4, 17'h09000, X_LD);
        add(0,0,0, 6'd4, 17'h09000, X_WB);
        add(0,0,0, 6'd5, 17'h09000, X_FET);
        add(0,0,0, 6'd5, 17'h07AB2, X_DEC);
        add(0,0,1, 6'd5, 17'h07AB2, X_ALU);   // BEQ taken -> 7
        add(0,0,0, 6'd7, 17'h07AB2, X_FET);
        add(0,0,0, 6'd7, 17'h0B005, X_DEC);
        add(0,0,0, 6'd7, 17'h0B005, X_NOP);   // JUMP 5
        add(0,0,0, 6'd5, 17'h0B005, X_FET);
        add(0,0,0, 6'd5, 17'h07AB2, X_DEC);
        add(0,0,0, 6'd5, 17'h07AB2, X_ALU);   // BEQ not taken -> 6
        add(0,0,0, 6'd6, 17'h07AB2, X_FET);
        add(0,0,0, 6'd6, 17'h0B001, X_DEC);
        add(0,0,0, 6'd6, 17'h0B001, X_NOP);   // JUMP 1
        add(0,0,0, 6'd1, 17'h0B001, X_FET);
        add(0,0,0, 6'd1, 17'h00678, X_DEC);

        reset_dut();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].stall, vecs[i].eq);
            chk($sformatf("tbl%0d.pc", i),   32'(bus.pc),   32'(vecs[i].pc));
            chk($sformatf("tbl%0d.ir", i),   32'(bus.ir),   32'(vecs[i].ir));
            chk($sformatf("tbl%0d.strb", i), 32'(strb()),   32'(vecs[i].strb));
            tick();
        end

        // ---------------- halt on jump-to-self, restart ----------------
        imem[1]  = 17'h0B010;
        imem[16] = 17'h0B010;
        reset_dut();
        drive(1'b0, 1'b0, 1'b0);
        chk("rst.pc",   32'(bus.pc), 32'd1);
        chk("rst.ir",   32'(bus.ir), 32'd0);
        chk("rst.strb", 32'(strb()), 32'(X_IDLE));
        drive(1'b1, 1'b0, 1'b0);
        tick();
        run_instr(1'b0, n);
        chk("jmp.pc", 32'(bus.pc), 32'd16);
        chk("jmp.cyc", 32'(n), 32'd3);
        run_instr(1'b0, n);
        chk("halt.strb", 32'(strb()), 32'(X_HALT));
        chk("halt.pc",   32'(bus.pc), 32'd16);
        tick();
        chk("halt.hold", 32'(strb()), 32'(X_HALT));
        drive(1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("restart.pc",   32'(bus.pc), 32'd1);
        chk("restart.strb", 32'(strb()), 32'(X_FET));

        // ---------------- stall during EXECUTE of ADD ----------------
        imem[1] = 17'h00678;
        reset_dut();
        drive(1'b1, 1'b0, 1'b0);
        tick();
        cyc = 0;
        drive(1'b0, 1'b0, 1'b0);
        tick(); cyc++;                  // FETCH -> DECODE
        tick(); cyc++;                  // DECODE -> EXECUTE
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            chk($sformatf("stall%0d.strb", k), 32'(strb()), 32'(X_NOP));
            chk($sformatf("stall%0d.pc", k),   32'(bus.pc), 32'd1);
            chk($sformatf("stall%0d.ir", k),   32'(bus.ir), 32'h00678);
            tick(); cyc++;
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("stall.alu", 32'(strb()), 32'(X_ALU));
        tick(); cyc++;
        chk("stall.wb", 32'(strb()), 32'(X_WB));
        tick(); cyc++;
        chk("stall.fet", 32'(strb()), 32'(X_FET));
        chk("stall.pc",  32'(bus.pc), 32'd2);
        chk("stall.cyc", 32'(cyc),    32'd7);

        // ---------------- reset during WRITEBACK ----------------
        reset_dut();
        drive(1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        chk("rwb.wb", 32'(strb()), 32'(X_WB));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        chk("rwb.strb", 32'(strb()), 32'(X_IDLE));
        chk("rwb.pc",   32'(bus.pc), 32'd1);
        chk("rwb.ir",   32'(bus.ir), 32'd0);

        // ---------------- PC wrap and branch wrap ----------------
        imem[1]  = 17'h0B03F;   // JUMP 63
        imem[63] = 17'h0F000;   // NOP
        imem[0]  = 17'h0B03E;   // JUMP 62
        imem[62] = 17'h07005;   // BEQ imm 5
        reset_dut();
        drive(1'b1, 1'b0, 1'b0);
        tick();
        run_instr(1'b0, n);
        chk("wrap.pc63", 32'(bus.pc), 32'd63);
        run_instr(1'b0, n);
        chk("wrap.pc0",  32'(bus.pc), 32'd0);
        chk("wrap.cyc",  32'(n),      32'd3);
        run_instr(1'b0, n);
        chk("wrap.pc62", 32'(bus.pc), 32'd62);
        run_instr(1'b1, n);
        chk("wrap.beq",  32'(bus.pc), 32'd3);

        // ---------------- Fibonacci loop ----------------
        imem[1] = 17'h07AB6;    // BEQ r10,r11 -> 7
        imem[2] = 17'h00312;    // r3 = r1 + r2
        imem[3] = 17'h00120;    // r1 = r2
        imem[4] = 17'h00230;    // r2 = r3
        imem[5] = 17'h00AAC;    // r10 = r10 + r12
        imem[6] = 17'h0B001;    // JUMP 1
        imem[7] = 17'h0B007;    // halt
        reset_dut();
        use_model = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        cyc = 0;
        while (!bus.halted && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk("fib.halted", 32'(bus.halted), 32'd1);
        chk("fib.pc",     32'(bus.pc),     32'd7);
        chk("fib.r10",    32'(regs[10]),   32'd7);
        chk("fib.r1",     32'(regs[1]),    32'd13);
        chk("fib.r2",     32'(regs[2]),    32'd21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle control FSM for the 64-entry, 17-bit instruction memory.
- Owns the program counter that drives the memory address and latches the fetched word into an instruction register.
- Decodes the 4-bit opcode and sequences datapath strobes: ALU, register write, data-memory read/write.
- Resolves BEQ and JUMP, and detects the jump-to-self halt idiom.

Parameters:
- ADDR_W, 6: instruction memory address width; PC wraps modulo 2^ADDR_W.
- INSTR_W, 17: instruction word width; the opcode is bits [15:12] and bit 16 is ignored.
- START_ADDR, 1: PC value after reset and on start.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution from IDLE or HALT.
- stall  in  1  freezes FSM, PC and IR while high.
- instr_in  in  INSTR_W  instruction memory read data (combinational from pc).
- eq_flag  in  1  datapath "operand A == operand B"; valid in EXECUTE.
- pc  out  ADDR_W  instruction memory address.
- ir_enable  out  1  IR load strobe, to the memory's IR_enable.
- ir  out  INSTR_W  latched instruction.
- alu_en  out  1  ALU operate strobe.
- reg_write  out  1  register file write strobe.
- mem_read  out  1  data memory read strobe (LOAD).
- mem_write  out  1  data memory write strobe (STORE).
- halted  out  1  high in HALT.
- busy  out  1  high in FETCH, DECODE, EXECUTE or WRITEBACK.

Behaviour:
- Reset: state=IDLE, pc=START_ADDR, ir=0, all strobes 0, halted=0, busy=0. Reset takes priority over stall and start, including mid-instruction.
- Opcode map:
  - 0000 ADD, 0100 XNOR, 0101 SHR, 0110 SHL: ALU class.
  - 1001 LOAD.
  - 1010 STORE.
  - 0111 BEQ.
  - 1011 JUMP.
  - All other opcodes: NOP.
- IDLE -> FETCH on start.
- FETCH:
  - ir_enable=1; ir <= instr_in at the clock edge.
  - Always -> DECODE.
- DECODE:
  - No strobes.
  - -> EXECUTE for every opcode, including NOP.
- EXECUTE, by opcode:
  - ALU class: alu_en=1, -> WRITEBACK.
  - LOAD: alu_en=1 (address calc), mem_read=1, -> WRITEBACK.
  - STORE: alu_en=1, mem_write=1, pc<=pc+1, -> FETCH.
  - BEQ: alu_en=1. If eq_flag, pc<=pc+ir[3:0] (zero-extended, mod 2^ADDR_W); else pc<=pc+1. -> FETCH.
  - JUMP: if ir[5:0]==pc, -> HALT with pc unchanged. Else pc<=ir[5:0], -> FETCH.
  - NOP: pc<=pc+1, -> FETCH.
- WRITEBACK: reg_write=1, pc<=pc+1, -> FETCH.
- Latency:
  - ALU class and LOAD: 4 cycles.
  - STORE, BEQ, JUMP, NOP: 3 cycles.
- HALT:
  - halted=1, busy=0.
  - start -> pc<=START_ADDR, -> FETCH.
- Stall: while stall=1, state, pc and ir hold and every strobe is forced to 0. Each strobe appears exactly once per instruction, in the first non-stalled cycle of its state.
- start is ignored while busy.
- PC wrap: 63+1 -> 0. A branch target such as 62+5 -> 3.
- All outputs are registered state or pure decode of state and ir, with no combinational path from instr_in.

Test Plan:
- Reset then start, memory holds 0x0678 at address 1 -> pc=1 in FETCH, ir=0x0678 after FETCH; EXECUTE then WRITEBACK reg_write pulse; pc=2 exactly 4 cycles after FETCH entry.
- BEQ 0x7AB2 at pc=5: eq_flag=1 -> next FETCH at pc=7; eq_flag=0 -> pc=6; both take 3 cycles.
- JUMP 0xB001 at pc=6 -> pc=1. JUMP 0xB010 at pc=16 -> HALT, halted=1, pc=16. start from HALT -> pc=1, FETCH.
- Stall held 3 cycles during EXECUTE of ADD -> state, pc, ir frozen and alu_en low while stalled; alu_en pulses once after release; total 7 cycles for the instruction.
- Reset asserted during WRITEBACK -> next cycle IDLE, pc=1, reg_write=0, ir=0. Opcode 1111 -> no strobes, pc+1 after 3 cycles.
- Wrap: NOP at pc=63 -> pc=0. BEQ taken, imm 5, at pc=62 -> pc=3. Full Fibonacci loop (addresses 1-7) with a behavioural datapath model: r10 counter reaches r11, then BEQ exits to address 7.
